// File: rtl/ram_bus_arbiter.sv
// Arbitrates the core's instruction-fetch and load/store ports onto the unified RAM strobe bus.
// One access every two cycles: grant -> RAM strobe -> response, with illegal accesses blocked at grant.
module ram_bus_arbiter #(
   parameter logic [31:0] DMEM_BASE   = 32'h0000_0800,
   parameter logic [31:0] SOC_ON_ADDR = 32'h0003_0000,
   parameter logic [31:0] MEM_TOP     = 32'h0000_1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   output logic        ls_err_o,
   output logic        ram_cs_o,
   output logic        ram_wr_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic        last_ls;
   logic        port_ls;
   logic        we_q;
   logic        err_q;
   logic        arb_en;
   logic        gnt_any;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_err;

   // Handshake: a port's gnt is high in the cycle its held req is accepted; exactly one
   // rvalid pulse follows two cycles later. Round-robin favours the port not granted last.
   always_comb begin
      arb_en    = rst_ni && (state != ACCESS);
      if_gnt_o  = arb_en && if_req_i && (!ls_req_i || last_ls);
      ls_gnt_o  = arb_en && ls_req_i && (!if_req_i || !last_ls);
      gnt_any   = if_gnt_o || ls_gnt_o;
      sel_we    = ls_gnt_o && ls_we_i;
      sel_addr  = ls_gnt_o ? ls_addr_i : if_addr_i;
      sel_wdata = ls_gnt_o ? ls_wdata_i : 32'h0;
      if (sel_we)
         sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr < DMEM_BASE) ||
                   ((sel_addr >= MEM_TOP) && (sel_addr != SOC_ON_ADDR));
      else
         sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_TOP);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         last_ls     <= 1'b0;
         port_ls     <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         ram_cs_o    <= 1'b0;
         ram_wr_o    <= 1'b0;
         ram_addr_o  <= 32'h0;
         ram_wdata_o <= 32'h0;
         if_rvalid_o <= 1'b0;
         ls_rvalid_o <= 1'b0;
         if_err_o    <= 1'b0;
         ls_err_o    <= 1'b0;
      end else begin
         // Strobes and responses are single-cycle pulses unless set below.
         ram_cs_o    <= 1'b0;
         ram_wr_o    <= 1'b0;
         ram_addr_o  <= 32'h0;
         ram_wdata_o <= 32'h0;
         if_rvalid_o <= 1'b0;
         ls_rvalid_o <= 1'b0;
         if_err_o    <= 1'b0;
         ls_err_o    <= 1'b0;
         case (state)
            ACCESS: begin
               state       <= RESP;
               if_rvalid_o <= !port_ls;
               ls_rvalid_o <= port_ls;
               if_err_o    <= !port_ls && err_q;
               ls_err_o    <= port_ls && err_q;
            end
            default: begin
               if (gnt_any) begin
                  state   <= ACCESS;
                  last_ls <= ls_gnt_o;
                  port_ls <= ls_gnt_o;
                  we_q    <= sel_we;
                  err_q   <= sel_err;
                  // An illegal access never reaches the RAM.
                  if (!sel_err) begin
                     ram_cs_o    <= 1'b1;
                     ram_wr_o    <= sel_we;
                     ram_addr_o  <= sel_addr;
                     ram_wdata_o <= sel_wdata;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign if_rdata_o = (if_rvalid_o && !err_q) ? ram_rdata_i : 32'h0;
   assign ls_rdata_o = (ls_rvalid_o && !we_q && !err_q) ? ram_rdata_i : 32'h0;
   assign busy_o     = (state != IDLE);

endmodule
